// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract datapath.
package serial_arith_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} serial_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result bus of serial_add_sub; the ovf_o wire exists only with SERIAL_SUB_OVF_EN.
// Handshake: operands transfer on a rising edge where start_i=1 and ready_o=1; the result
// transfers on a rising edge where valid_o=1 and ack_i=1. Neither side may retract early.
interface serial_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             ready_o;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             valid_o;
  logic             ack_i;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_o;

  modport slave  (input  start_i, sub_i, a_i, b_i, ack_i,
                  output ready_o, result_o, carry_o, valid_o, ovf_o);
  modport master (output start_i, sub_i, a_i, b_i, ack_i,
                  input  ready_o, result_o, carry_o, valid_o, ovf_o);
`else
  modport slave  (input  start_i, sub_i, a_i, b_i, ack_i,
                  output ready_o, result_o, carry_o, valid_o);
  modport master (output start_i, sub_i, a_i, b_i, ack_i,
                  input  ready_o, result_o, carry_o, valid_o);
`endif
endinterface

// File: rtl/serial_fa_cell.sv
// One full-adder cell with its carry flop; o_carry (carry currently fed into the cell)
// is exported only when SERIAL_SUB_OVF_EN is defined.
module serial_fa_cell (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_a,
  input  logic i_b,
  input  logic i_load,
  input  logic i_seed,
  input  logic i_en,
  output logic o_sum,
  output logic o_cout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic o_carry
`endif
);

  logic r_carry;

  assign o_sum  = i_a ^ i_b ^ r_carry;
  assign o_cout = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);

`ifdef SERIAL_SUB_OVF_EN
  assign o_carry = r_carry;
`endif

  // Load wins over enable so a new operation always starts from its seed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_carry <= i_seed;
    end else if (i_en) begin
      r_carry <= o_cout;
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow output ovf_o.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  serial_add_sub_if.slave bus,
  output serial_state_t dbg_state_o
);

  serial_state_t    r_state;
  serial_state_t    w_next_state;
  logic             w_ready;
  logic             w_valid;
  logic             w_load;
  logic             w_en;
  logic             w_last;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_o;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_shift_cat;
  logic [WIDTH-1:0] w_sh_next;

  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  // Slicing the concatenation keeps the WIDTH=1 case free of an empty range.
  assign w_shift_cat = {w_sum, r_sh};
  assign w_sh_next   = w_shift_cat[WIDTH:1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.start_i) w_next_state = ST_RUN;
      ST_RUN:  if (w_last)      w_next_state = ST_DONE;
      ST_DONE: if (bus.ack_i)   w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        w_load  = bus.start_i;
      end
      ST_RUN:  w_en    = 1'b1;
      ST_DONE: w_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic w_cin;
  logic r_ovf;

  serial_fa_cell u_fa (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_a     (r_sa[0]),
    .i_b     (r_sb[0]),
    .i_load  (w_load),
    .i_seed  (bus.sub_i == OP_SUB),
    .i_en    (w_en),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_carry (w_cin)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_en && w_last) begin
      r_ovf <= w_cin ^ w_cout;
    end
  end

  assign bus.ovf_o = r_ovf;
`else
  serial_fa_cell u_fa (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_a     (r_sa[0]),
    .i_b     (r_sb[0]),
    .i_load  (w_load),
    .i_seed  (bus.sub_i == OP_SUB),
    .i_en    (w_en),
    .o_sum   (w_sum),
    .o_cout  (w_cout)
  );
`endif

  // Result and carry outputs update only on the last bit so they hold through the next RUN.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sa      <= '0;
      r_sb      <= '0;
      r_sh      <= '0;
      r_result  <= '0;
      r_carry_o <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_sa  <= bus.a_i;
        r_sb  <= (bus.sub_i == OP_SUB) ? ~bus.b_i : bus.b_i;
        r_cnt <= '0;
      end else if (w_en) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_sh  <= w_sh_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_en && w_last) begin
        r_result  <= w_sh_next;
        r_carry_o <= w_cout;
      end
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = w_valid;
  assign bus.result_o = r_result;
  assign bus.carry_o  = r_carry_o;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH 8, 1 and 32; ovf_o is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_add_sub;
  import serial_arith_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_delay8  = -1;
  int   ack_delay32 = -1;

  logic [63:0] exp_q8[$];
  logic [63:0] exp_q32[$];

  serial_state_t st8, st1, st32;

  serial_add_sub_if #(.WIDTH(8))  if8 ();
  serial_add_sub_if #(.WIDTH(1))  if1 ();
  serial_add_sub_if #(.WIDTH(32)) if32 ();

  serial_add_sub #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_n_i(rst_n), .bus(if8.slave),  .dbg_state_o(st8));
  serial_add_sub #(.WIDTH(1))  u_dut1  (.clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave),  .dbg_state_o(st1));
  serial_add_sub #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(if32.slave), .dbg_state_o(st32));

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: unsigned/signed arithmetic on plain integers; returns {ovf, carry, result[31:0]}.
  function automatic logic [63:0] ref_model(input int w, input logic sub,
                                            input logic [31:0] a, input logic [31:0] b);
    longint m    = longint'(1) << w;
    longint ua   = longint'(a) & (m - 1);
    longint ub   = longint'(b) & (m - 1);
    longint r, sa, sbv, sv;
    logic   c, v;
    if (sub) begin
      r = ua - ub;
      c = (ua >= ub);
    end else begin
      r = ua + ub;
      c = (r >= m);
    end
    if (r < 0)  r = r + m;
    if (r >= m) r = r - m;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    sv  = sub ? sa - sbv : sa + sbv;
    v   = (sv < -(m / 2)) || (sv >= m / 2);
    return {30'b0, v, c, r[31:0]};
  endfunction

  function automatic logic [63:0] pack8();
    logic ovf = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf = if8.ovf_o;
`endif
    return {30'b0, ovf, if8.carry_o, 24'b0, if8.result_o};
  endfunction

  function automatic logic [63:0] pack32();
    logic ovf = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf = if32.ovf_o;
`endif
    return {30'b0, ovf, if32.carry_o, if32.result_o};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic issue8(input logic sub, input logic [7:0] a, input logic [7:0] b);
    for (int t = 0; t < 200 && !if8.ready_o; t++) @(negedge clk);
    if (!if8.ready_o) begin
      check("issue8_ready_timeout", 64'd0, 64'd1);
      return;
    end
    if8.start_i = 1'b1;
    if8.sub_i   = sub;
    if8.a_i     = a;
    if8.b_i     = b;
    exp_q8.push_back(ref_model(8, sub, {24'b0, a}, {24'b0, b}));
    @(posedge clk);
    #1;
    if8.start_i = 1'b0;
    if8.a_i     = 8'($urandom);
    if8.b_i     = 8'($urandom);
    if8.sub_i   = 1'($urandom);
  endtask

  task automatic issue32(input logic sub, input logic [31:0] a, input logic [31:0] b);
    for (int t = 0; t < 200 && !if32.ready_o; t++) @(negedge clk);
    if (!if32.ready_o) begin
      check("issue32_ready_timeout", 64'd0, 64'd1);
      return;
    end
    if32.start_i = 1'b1;
    if32.sub_i   = sub;
    if32.a_i     = a;
    if32.b_i     = b;
    exp_q32.push_back(ref_model(32, sub, a, b));
    @(posedge clk);
    #1;
    if32.start_i = 1'b0;
    if32.a_i     = $urandom;
    if32.b_i     = $urandom;
  endtask

  task automatic drain8();
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (exp_q8.size() == 0) && if8.ready_o && !if8.valid_o;
    end
    if (!done) check("drain8_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain32();
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (exp_q32.size() == 0) && if32.ready_o && !if32.valid_o;
    end
    if (!done) check("drain32_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin : mon8
    logic [63:0] got;
    logic [63:0] exp;
    int d;
    if8.ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && if8.valid_o) begin
        got = pack8();
        d = (ack_delay8 < 0) ? $urandom_range(0, 3) : ack_delay8;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("hold8", pack8(), got);
        end
        if (exp_q8.size() == 0) begin
          check("unexpected_result8", 64'd1, 64'd0);
        end else begin
          exp = exp_q8.pop_front();
          check("result8", got[31:0], exp[31:0]);
          check("carry8", {63'b0, got[32]}, {63'b0, exp[32]});
`ifdef SERIAL_SUB_OVF_EN
          check("ovf8", {63'b0, got[33]}, {63'b0, exp[33]});
`endif
        end
        if8.ack_i = 1'b1;
        @(posedge clk);
        #1;
        if8.ack_i = 1'b0;
        check("valid_drop8", {63'b0, if8.valid_o}, 64'd0);
        check("ready_ret8", {63'b0, if8.ready_o}, 64'd1);
      end
    end
  end

  initial begin : mon32
    logic [63:0] got;
    logic [63:0] exp;
    int d;
    if32.ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && if32.valid_o) begin
        got = pack32();
        d = (ack_delay32 < 0) ? $urandom_range(0, 3) : ack_delay32;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("hold32", pack32(), got);
        end
        if (exp_q32.size() == 0) begin
          check("unexpected_result32", 64'd1, 64'd0);
        end else begin
          exp = exp_q32.pop_front();
          check("result32", got[31:0], exp[31:0]);
          check("carry32", {63'b0, got[32]}, {63'b0, exp[32]});
`ifdef SERIAL_SUB_OVF_EN
          check("ovf32", {63'b0, got[33]}, {63'b0, exp[33]});
`endif
        end
        if32.ack_i = 1'b1;
        @(posedge clk);
        #1;
        if32.ack_i = 1'b0;
        check("valid_drop32", {63'b0, if32.valid_o}, 64'd0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0] e1;
    rst_n = 1'b0;
    if8.start_i = 1'b0;  if8.sub_i = 1'b0;  if8.a_i = '0;  if8.b_i = '0;
    if1.start_i = 1'b0;  if1.sub_i = 1'b0;  if1.a_i = '0;  if1.b_i = '0;  if1.ack_i = 1'b0;
    if32.start_i = 1'b0; if32.sub_i = 1'b0; if32.a_i = '0; if32.b_i = '0;
    repeat (3) @(negedge clk);

    check("rst_ready8",  {63'b0, if8.ready_o},  64'd1);
    check("rst_valid8",  {63'b0, if8.valid_o},  64'd0);
    check("rst_result8", {56'b0, if8.result_o}, 64'd0);
    check("rst_carry8",  {63'b0, if8.carry_o},  64'd0);
    check("rst_state8",  {62'b0, st8},          {62'b0, ST_IDLE});
    check("rst_ready1",  {63'b0, if1.ready_o},  64'd1);
    check("rst_valid1",  {63'b0, if1.valid_o},  64'd0);
    check("rst_ready32", {63'b0, if32.ready_o}, 64'd1);
    check("rst_result32",{32'b0, if32.result_o},64'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf8",    {63'b0, if8.ovf_o},    64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Sub 5-3 with latency check: valid must rise exactly WIDTH edges after accept.
    ack_delay8 = 2;
    issue8(OP_SUB, 8'h05, 8'h03);
    repeat (7) @(posedge clk);
    #1;
    check("latency_early8", {63'b0, if8.valid_o}, 64'd0);
    @(posedge clk);
    #1;
    check("latency_valid8", {63'b0, if8.valid_o}, 64'd1);
    drain8();

    ack_delay8 = -1;
    issue8(OP_SUB, 8'h03, 8'h05);
    issue8(OP_ADD, 8'hFF, 8'h01);
    issue8(OP_ADD, 8'h7F, 8'h01);
    drain8();

    // Long consumer stall: outputs must hold.
    ack_delay8 = 20;
    issue8(OP_SUB, 8'h80, 8'h01);
    drain8();
    ack_delay8 = -1;

    // start_i during RUN is ignored.
    issue8(OP_ADD, 8'h12, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    if8.start_i = 1'b1; if8.sub_i = 1'b1; if8.a_i = 8'hFF; if8.b_i = 8'hFF;
    check("busy_ready8", {63'b0, if8.ready_o}, 64'd0);
    @(posedge clk);
    #1;
    if8.start_i = 1'b0;
    drain8();

    // Reset at RUN bit 4 aborts the operation and clears outputs at once.
    issue8(OP_SUB, 8'h55, 8'h0F);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_state8", {62'b0, st8}, {62'b0, ST_RUN});
    rst_n = 1'b0;
    #1;
    check("abort_valid8",  {63'b0, if8.valid_o},  64'd0);
    check("abort_ready8",  {63'b0, if8.ready_o},  64'd1);
    check("abort_result8", {56'b0, if8.result_o}, 64'd0);
    check("abort_carry8",  {63'b0, if8.carry_o},  64'd0);
    exp_q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(OP_ADD, 8'h3C, 8'h0A);
    issue8(OP_SUB, 8'h00, 8'h00);
    drain8();

    // WIDTH=1: 1+1, one-cycle latency.
    e1 = ref_model(1, OP_ADD, 32'd1, 32'd1);
    if1.start_i = 1'b1; if1.sub_i = OP_ADD; if1.a_i = 1'b1; if1.b_i = 1'b1;
    @(posedge clk);
    #1;
    if1.start_i = 1'b0;
    check("w1_not_yet", {63'b0, if1.valid_o}, 64'd0);
    @(posedge clk);
    #1;
    check("w1_valid",  {63'b0, if1.valid_o},  64'd1);
    check("w1_result", {63'b0, if1.result_o}, {63'b0, e1[0]});
    check("w1_carry",  {63'b0, if1.carry_o},  {63'b0, e1[32]});
`ifdef SERIAL_SUB_OVF_EN
    check("w1_ovf",    {63'b0, if1.ovf_o},    {63'b0, e1[33]});
`endif
    if1.ack_i = 1'b1;
    @(posedge clk);
    #1;
    if1.ack_i = 1'b0;
    check("w1_valid_drop", {63'b0, if1.valid_o}, 64'd0);
    check("w1_ready_ret",  {63'b0, if1.ready_o}, 64'd1);

    // Randomized WIDTH=32 traffic with random consumer delay.
    for (int n = 0; n < 1200; n++) begin
      issue32(1'($urandom_range(0, 1)), pick32(), pick32());
    end
    drain32();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
